// File: rtl/rv32_decode.sv
// rv32_decode: RV32I decode stage with integer register file.
//   Decodes instr_in combinationally, reads rs1/rs2 (with same-cycle
//   writeback bypass), and registers the decoded bundle on posedge clk.
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   stall_in, flush_in          hold outputs / insert bubble (stall wins)
//   pc_in, instr_in             from fetch
//   rd_write_in/rd_in/rd_value_in  writeback port into the register file
//   *_out                       registered decode bundle for execute
// Instructions that do not name a source/destination register report 0 for
// that register number (and value), so the hazard unit sees no false deps.
module rv32_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        rd_write_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] rd_value_in,
  output logic [31:0] pc_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic [31:0] rs1_value_out,
  output logic [31:0] rs2_value_out,
  output logic [31:0] imm_out,
  output logic [3:0]  alu_op_out,
  output logic        alu_src1_pc_out,
  output logic        alu_src2_imm_out,
  output logic        branch_out,
  output logic [2:0]  branch_op_out,
  output logic        jump_out,
  output logic        jalr_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [2:0]  mem_width_out,
  output logic        rd_write_out,
  output logic        illegal_out
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] regs [0:31];

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [4:0]  c_rs1, c_rs2, c_rd;
  logic [31:0] c_imm, c_v1, c_v2;
  logic [3:0]  c_alu_op;
  logic        c_src1_pc, c_src2_imm, c_branch, c_jump, c_jalr;
  logic        c_mem_read, c_mem_write, c_wr, c_illegal;
  logic [2:0]  c_bop, c_width;

  assign opc   = instr_in[6:0];
  assign f3    = instr_in[14:12];
  assign f7    = instr_in[31:25];
  assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                  instr_in[11:8], 1'b0};
  assign imm_u = {instr_in[31:12], 12'b0};
  assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                  instr_in[30:21], 1'b0};

  always_comb begin
    c_rs1 = '0; c_rs2 = '0; c_rd = '0; c_imm = '0; c_alu_op = '0;
    c_src1_pc = 1'b0; c_src2_imm = 1'b0; c_branch = 1'b0; c_bop = '0;
    c_jump = 1'b0; c_jalr = 1'b0; c_mem_read = 1'b0; c_mem_write = 1'b0;
    c_width = '0; c_wr = 1'b0; c_illegal = 1'b0;
    case (opc)
      OP_LUI: begin
        c_rd = instr_in[11:7]; c_wr = 1'b1; c_imm = imm_u; c_src2_imm = 1'b1;
      end
      OP_AUIPC: begin
        c_rd = instr_in[11:7]; c_wr = 1'b1; c_imm = imm_u;
        c_src1_pc = 1'b1; c_src2_imm = 1'b1;
      end
      OP_JAL: begin
        c_rd = instr_in[11:7]; c_wr = 1'b1; c_imm = imm_j;
        c_src1_pc = 1'b1; c_jump = 1'b1;
      end
      OP_JALR: begin
        c_rs1 = instr_in[19:15]; c_rd = instr_in[11:7]; c_wr = 1'b1; c_imm = imm_i;
        c_src1_pc = 1'b1; c_jump = 1'b1; c_jalr = 1'b1;
      end
      OP_BRANCH: begin
        if (f3 == 3'b010 || f3 == 3'b011) c_illegal = 1'b1;
        else begin
          c_rs1 = instr_in[19:15]; c_rs2 = instr_in[24:20]; c_imm = imm_b;
          c_branch = 1'b1; c_bop = f3;
        end
      end
      OP_LOAD: begin
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) c_illegal = 1'b1;
        else begin
          c_rs1 = instr_in[19:15]; c_rd = instr_in[11:7]; c_wr = 1'b1; c_imm = imm_i;
          c_src2_imm = 1'b1; c_mem_read = 1'b1; c_width = f3;
        end
      end
      OP_STORE: begin
        if (f3[2] || f3 == 3'b011) c_illegal = 1'b1;
        else begin
          c_rs1 = instr_in[19:15]; c_rs2 = instr_in[24:20]; c_imm = imm_s;
          c_src2_imm = 1'b1; c_mem_write = 1'b1; c_width = f3;
        end
      end
      OP_IMM: begin
        // Shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 30.
        if ((f3 == 3'b001 && f7 != 7'h00) ||
            (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) c_illegal = 1'b1;
        else begin
          c_rs1 = instr_in[19:15]; c_rd = instr_in[11:7]; c_wr = 1'b1; c_imm = imm_i;
          c_src2_imm = 1'b1;
          c_alu_op = {(f3 == 3'b001 || f3 == 3'b101) ? instr_in[30] : 1'b0, f3};
        end
      end
      OP_OP: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          c_rs1 = instr_in[19:15]; c_rs2 = instr_in[24:20]; c_rd = instr_in[11:7];
          c_wr = 1'b1; c_alu_op = {instr_in[30], f3};
        end else c_illegal = 1'b1;
      end
      OP_MISC, OP_SYSTEM: ;
      default: c_illegal = 1'b1;
    endcase
  end

  // Register read with same-cycle writeback bypass; regs[0] is never written.
  always_comb begin
    c_v1 = '0;
    if (c_rs1 != 5'd0)
      c_v1 = (rd_write_in && rd_in == c_rs1) ? rd_value_in : regs[c_rs1];
  end

  always_comb begin
    c_v2 = '0;
    if (c_rs2 != 5'd0)
      c_v2 = (rd_write_in && rd_in == c_rs2) ? rd_value_in : regs[c_rs2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rd_write_in && rd_in != 5'd0) begin
      regs[rd_in] <= rd_value_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out <= '0; rs1_out <= '0; rs2_out <= '0; rd_out <= '0;
      rs1_value_out <= '0; rs2_value_out <= '0; imm_out <= '0; alu_op_out <= '0;
      alu_src1_pc_out <= 1'b0; alu_src2_imm_out <= 1'b0; branch_out <= 1'b0;
      branch_op_out <= '0; jump_out <= 1'b0; jalr_out <= 1'b0;
      mem_read_out <= 1'b0; mem_write_out <= 1'b0; mem_width_out <= '0;
      rd_write_out <= 1'b0; illegal_out <= 1'b0;
    end else if (!stall_in) begin
      pc_out <= pc_in;
      if (flush_in) begin
        rs1_out <= '0; rs2_out <= '0; rd_out <= '0;
        rs1_value_out <= '0; rs2_value_out <= '0; imm_out <= '0; alu_op_out <= '0;
        alu_src1_pc_out <= 1'b0; alu_src2_imm_out <= 1'b0; branch_out <= 1'b0;
        branch_op_out <= '0; jump_out <= 1'b0; jalr_out <= 1'b0;
        mem_read_out <= 1'b0; mem_write_out <= 1'b0; mem_width_out <= '0;
        rd_write_out <= 1'b0; illegal_out <= 1'b0;
      end else begin
        rs1_out <= c_rs1; rs2_out <= c_rs2; rd_out <= c_rd;
        rs1_value_out <= c_v1; rs2_value_out <= c_v2; imm_out <= c_imm;
        alu_op_out <= c_alu_op; alu_src1_pc_out <= c_src1_pc;
        alu_src2_imm_out <= c_src2_imm; branch_out <= c_branch;
        branch_op_out <= c_bop; jump_out <= c_jump; jalr_out <= c_jalr;
        mem_read_out <= c_mem_read; mem_write_out <= c_mem_write;
        mem_width_out <= c_width; rd_write_out <= c_wr && (c_rd != 5'd0);
        illegal_out <= c_illegal;
      end
    end
  end

endmodule
